classify_scheduler: RTL and testbench

Sequencer for the MNIST classification path: it turns the camera frame boundary into start pulses for the classifier, waits for its completion, and filters the raw predictions into a stable, debounced digit for the LEDs and seven-segment display. It sits in the `clk` domain between the camera `vsync` input, the `mnist_classifier` start/done handshake, and the result-capture logic that feeds the display outputs. It replaces the ad-hoc vsync edge detection and direct result latch at the top level.

---
 rtl/classify_sched_pkg.sv | 21 ++
 rtl/vsync_edge_sync.sv | 40 ++++
 rtl/classify_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_classify_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/classify_sched_pkg.sv
// Shared types and constants for the MNIST classification scheduler.
//   cls_state_t : scheduler FSM states
//   NO_RESULT   : result code meaning "no accepted digit"
//   MAX_DIGIT   : largest valid classifier prediction
//   DIV_W/CNT_W : frame divider and vote run-counter widths
package classify_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    START      = 3'd2,
    RUN        = 3'd3,
    EVAL       = 3'd4
  } cls_state_t;

  localparam logic [3:0]  NO_RESULT = 4'hF;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;
  localparam int unsigned DIV_W     = 8;   // FRAME_DIV up to 255
  localparam int unsigned CNT_W     = 4;   // STABLE_COUNT up to 15

endpackage

// File: rtl/vsync_edge_sync.sv
// Camera vsync synchronizer and falling-edge detector.
//   clk, rst     : clock, asynchronous active-high reset
//   vsync_in     : raw vsync, asynchronous to clk
//   edge_pulse   : registered single-cycle pulse per synchronized falling edge
module vsync_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;

  // Shift chain, previous-sample flop and fall detect (previous=1, current=0)
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], vsync_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  // Chain resets low so a line already high after reset is not seen as a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign edge_pulse = pulse_q;

endmodule

// File: rtl/classify_scheduler.sv
// Sequencer for the MNIST classification path: divides camera frame edges
// into classifier start pulses, waits for completion, and debounces the
// predictions into a stable displayed digit.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : level, 0 stops new starts
//   vsync_in        : raw camera vsync (asynchronous)
//   cls_start       : one-cycle classifier start pulse
//   cls_done        : classifier completion pulse
//   cls_prediction  : classifier digit, valid with cls_done
//   result          : debounced digit, 4'hF when none
//   result_valid    : result holds an accepted digit
//   busy            : classification outstanding
//   timeout_err     : sticky watchdog flag
// Build option: define CLASSIFY_SCHED_WATCHDOG_EN to add the RUN watchdog;
// otherwise RUN waits indefinitely and timeout_err is tied low.
module classify_scheduler
  import classify_sched_pkg::*;
#(
  parameter int unsigned FRAME_DIV      = 2,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vsync_in,
  output logic       cls_start,
  input  logic       cls_done,
  input  logic [3:0] cls_prediction,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE   = CNT_W'(STABLE_COUNT);

  cls_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       pred_q, pred_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]       result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             cls_start_q, cls_start_d;
  logic             busy_q, busy_d;

  logic             frame_edge;
  logic [3:0]       vote_cand;
  logic [CNT_W-1:0] vote_cnt;
  logic             vote_hit;
  logic             wd_timeout;

  vsync_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_vsync_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .edge_pulse (frame_edge)
  );

`ifdef CLASSIFY_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Counts RUN cycles; cleared whenever the FSM is elsewhere
  always_comb begin
    wd_cnt_d   = '0;
    wd_timeout = 1'b0;
    if (state_q == RUN) begin
      wd_cnt_d   = wd_cnt_q + WD_W'(1);
      wd_timeout = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign wd_timeout         = 1'b0;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign timeout_err        = 1'b0;
`endif

  // Vote on the captured prediction: invalid clears the run, repeats extend it
  always_comb begin
    vote_cand = cand_q;
    vote_cnt  = run_cnt_q;
    vote_hit  = 1'b0;
    if (pred_q > MAX_DIGIT) begin
      vote_cnt = '0;
    end else begin
      if ((pred_q == cand_q) && (run_cnt_q != '0)) begin
        vote_cnt = (run_cnt_q >= STABLE) ? STABLE : run_cnt_q + CNT_W'(1);
      end else begin
        vote_cand = pred_q;
        vote_cnt  = CNT_W'(1);
      end
      vote_hit = (vote_cnt == STABLE);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    pred_d         = pred_q;
    cand_d         = cand_q;
    run_cnt_d      = run_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cls_start_d    = 1'b0;
    busy_d         = 1'b0;
`ifdef CLASSIFY_SCHED_WATCHDOG_EN
    timeout_err_d  = timeout_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (enable) state_d = WAIT_FRAME;
      end

      WAIT_FRAME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_edge) begin
          if (div_q >= DIV_LAST) begin
            div_d       = '0;
            state_d     = START;
            cls_start_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end

      START: begin
        state_d = RUN;
        busy_d  = 1'b1;
      end

      // Done wins over a same-cycle timeout
      RUN: begin
        if (cls_done) begin
          pred_d  = cls_prediction;
          state_d = EVAL;
        end else if (wd_timeout) begin
`ifdef CLASSIFY_SCHED_WATCHDOG_EN
          timeout_err_d = 1'b1;
`endif
          run_cnt_d = '0;
          state_d   = enable ? WAIT_FRAME : IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end

      EVAL: begin
        cand_d    = vote_cand;
        run_cnt_d = vote_cnt;
        if (vote_hit) begin
          result_d       = vote_cand;
          result_valid_d = 1'b1;
        end
        state_d = enable ? WAIT_FRAME : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      div_q          <= '0;
      pred_q         <= '0;
      cand_q         <= NO_RESULT;
      run_cnt_q      <= '0;
      result_q       <= NO_RESULT;
      result_valid_q <= 1'b0;
      cls_start_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      pred_q         <= pred_d;
      cand_q         <= cand_d;
      run_cnt_q      <= run_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      cls_start_q    <= cls_start_d;
      busy_q         <= busy_d;
    end
  end

  assign cls_start    = cls_start_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_classify_scheduler.sv
// Directed self-checking bench for classify_scheduler
// (FRAME_DIV=2, STABLE_COUNT=3, SYNC_STAGES=2).
module tb_classify_scheduler;

`ifdef CLASSIFY_SCHED_WATCHDOG_EN
  localparam int unsigned TB_TIMEOUT = 50;
  localparam int          DONE_GAP   = 20;
`else
  localparam int unsigned TB_TIMEOUT = 200000;
  localparam int          DONE_GAP   = 100;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       vsync_in;
  logic       cls_start;
  logic       cls_done;
  logic [3:0] cls_prediction;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;
  logic       timeout_err;

  int n_chk = 0;
  int n_bad = 0;
  int n_start = 0;
  int long_start = 0;
  logic start_prev = 1'b0;

  classify_scheduler #(
    .FRAME_DIV      (2),
    .STABLE_COUNT   (3),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .SYNC_STAGES    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .vsync_in       (vsync_in),
    .cls_start      (cls_start),
    .cls_done       (cls_done),
    .cls_prediction (cls_prediction),
    .result         (result),
    .result_valid   (result_valid),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Count start pulses and flag any pulse wider than one cycle
  always @(posedge clk) begin
    if (cls_start) begin
      n_start <= n_start + 1;
      if (start_prev) long_start <= long_start + 1;
    end
    start_prev <= cls_start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vsync fall; lat = cycles from the fall to cls_start, -1 if none
  task automatic fall_and_watch(output int lat);
    lat = -1;
    vsync_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cls_start && lat < 0) lat = i;
    end
    vsync_in = 1'b1;
    repeat (3) tick();
  endtask

  task automatic done_after(input int n, input logic [3:0] p);
    repeat (n) tick();
    cls_done = 1'b1;
    cls_prediction = p;
    tick();
    cls_done = 1'b0;
    cls_prediction = 4'd0;
  endtask

  // Two frame edges (second one qualifies), then done with prediction p and EVAL
  task automatic classify(input string tag, input logic [3:0] p);
    int lat;
    fall_and_watch(lat);
    chk({tag, "_edge1_nostart"}, lat, 32'hFFFF_FFFF);
    fall_and_watch(lat);
    chk({tag, "_start_lat"}, lat, 32'd4);
    done_after(DONE_GAP, p);
    chk({tag, "_busy_drop"}, busy, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int lat;
    int s0;
    int n;
    rst = 1'b1;
    enable = 1'b0;
    vsync_in = 1'b1;
    cls_done = 1'b0;
    cls_prediction = 4'd0;
    repeat (3) tick();

    chk("rst_cls_start", cls_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 4'hF);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);

    rst = 1'b0;
    tick();
    enable = 1'b1;
    repeat (5) tick();

    // Divider and debounce: 7,7,3,3,3
    classify("p7a", 4'd7);
    chk("p7a_result", result, 4'hF);
    classify("p7b", 4'd7);
    chk("p7b_result", result, 4'hF);
    classify("p3a", 4'd3);
    chk("p3a_result", result, 4'hF);
    chk("div_three_starts", n_start, 32'd3);
    classify("p3b", 4'd3);
    chk("p3b_result", result, 4'hF);
    chk("p3b_valid", result_valid, 1'b0);
    classify("p3c", 4'd3);
    chk("p3c_result", result, 4'd3);
    chk("p3c_valid", result_valid, 1'b1);

    // Invalid prediction: 5,5,12,5 then 5,5 to prove the count restarted at 1
    do_reset();
    classify("i5a", 4'd5);
    classify("i5b", 4'd5);
    classify("i12", 4'd12);
    chk("i12_result", result, 4'hF);
    classify("i5c", 4'd5);
    chk("i5c_result", result, 4'hF);
    classify("i5d", 4'd5);
    chk("i5d_result", result, 4'hF);
    classify("i5e", 4'd5);
    chk("i5e_result", result, 4'd5);
    chk("i5e_valid", result_valid, 1'b1);

    // Stray done before any start, then edges during RUN
    do_reset();
    s0 = n_start;
    cls_done = 1'b1;
    cls_prediction = 4'd2;
    tick();
    cls_done = 1'b0;
    repeat (3) tick();
    chk("stray_busy", busy, 1'b0);
    chk("stray_result", result, 4'hF);
    fall_and_watch(lat);
    chk("run_edge1", lat, 32'hFFFF_FFFF);
    fall_and_watch(lat);
    chk("run_start", lat, 32'd4);
    for (int k = 0; k < 3; k++) begin
      fall_and_watch(lat);
      chk("run_edge_nostart", lat, 32'hFFFF_FFFF);
    end
    chk("run_still_busy", busy, 1'b1);
    done_after(5, 4'd8);
    tick();
    chk("run_one_start", n_start - s0, 32'd1);
    classify("d8b", 4'd8);  // divider must be back at 0 here

    // Build result=4, dropping enable during the last RUN
    classify("q4a", 4'd4);
    classify("q4b", 4'd4);
    fall_and_watch(lat);
    fall_and_watch(lat);
    chk("q4c_start", lat, 32'd4);
    enable = 1'b0;
    done_after(5, 4'd4);
    tick();
    chk("endrop_result", result, 4'd4);
    chk("endrop_valid", result_valid, 1'b1);
    s0 = n_start;
    fall_and_watch(lat);
    fall_and_watch(lat);
    chk("endrop_no_start", n_start - s0, 32'd0);
    enable = 1'b1;
    tick();

    // Reset applied mid-RUN
    fall_and_watch(lat);
    fall_and_watch(lat);
    chk("mid_busy", busy, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_result", result, 4'hF);
    chk("mid_rst_valid", result_valid, 1'b0);
    chk("mid_rst_start", cls_start, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    s0 = n_start;
    cls_done = 1'b1;
    cls_prediction = 4'd6;
    tick();
    cls_done = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_result", result, 4'hF);
    chk("post_rst_no_start", n_start - s0, 32'd0);

`ifdef CLASSIFY_SCHED_WATCHDOG_EN
    // Watchdog: no done, timeout after 50 RUN cycles
    fall_and_watch(lat);
    vsync_in = 1'b0;
    n = 0;
    while (!cls_start && n < 10) begin
      tick();
      n++;
    end
    chk("wd_start_seen", cls_start, 1'b1);
    vsync_in = 1'b1;
    tick();
    chk("wd_busy", busy, 1'b1);
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 32'd50);
    chk("wd_busy_drop", busy, 1'b0);
    chk("wd_result_kept", result, 4'hF);
    fall_and_watch(lat);
    chk("wd_edge1", lat, 32'hFFFF_FFFF);
    fall_and_watch(lat);
    chk("wd_restart", lat, 32'd4);
    done_after(5, 4'd1);
    tick();
    chk("wd_sticky", timeout_err, 1'b1);
`else
    n = 0;
    chk("no_wd_timeout", timeout_err, 1'b0);
`endif

    chk("start_width", long_start, 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
